// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle: register IDs and stage flags in,
// forwarding selects, stalls, flushes and status out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1D, rs2D, rs1E, rs2E;
  logic [4:0]       rdE, rdM, rdW;
  logic             regWriteM, regWriteW;
  logic             loadE, pcSrcE;
  logic             memReqM, memReadyM;
  logic [1:0]       forwardAE, forwardBE;
  logic             stallF, stallD, stallE, stallM;
  logic             flushD, flushE, flushW;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
           regWriteM, regWriteW, loadE, pcSrcE, memReqM, memReadyM,
    input  forwardAE, forwardBE, stallF, stallD, stallE, stallM,
           flushD, flushE, flushW, mem_err, stall_cnt
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
           regWriteM, regWriteW, loadE, pcSrcE, memReqM, memReadyM,
    output forwardAE, forwardBE, stallF, stallD, stallE, stallM,
           flushD, flushE, flushW, mem_err, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: operand forwarding,
// load-use / branch / memory-wait stall and flush, memory timeout tracking.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t             state, next_state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               mem_err_q;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic               mem_stall, lw_stall;

  // Memory stage has the younger result, so it wins over Writeback; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic wr_m,
                                         input logic [4:0] rd_w, input logic wr_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  always_comb begin
    mem_stall = hz.memReqM && !hz.memReadyM;
    lw_stall  = hz.loadE && hz.rdE != 5'd0 &&
                (hz.rdE == hz.rs1D || hz.rdE == hz.rs2D);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= next_state;
  end

  // A dropped request also ends the wait; a timeout keeps us waiting.
  always_comb begin
    next_state = state;
    case (state)
      S_RUN:   if (mem_stall) next_state = S_WAIT;
      S_WAIT:  if (hz.memReadyM || !hz.memReqM) next_state = S_RUN;
      default: next_state = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (next_state == S_WAIT) begin
        if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) mem_err_q <= 1'b1;
      if (hz.stallF && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // A frozen pipeline defers load-use and branch handling until memory responds.
  always_comb begin
    hz.forwardAE = 2'b00;
    hz.forwardBE = 2'b00;
    hz.stallF    = 1'b0;
    hz.stallD    = 1'b0;
    hz.stallE    = 1'b0;
    hz.stallM    = 1'b0;
    hz.flushD    = 1'b0;
    hz.flushE    = 1'b0;
    hz.flushW    = 1'b0;
    if (rst) begin
      hz.flushD = 1'b1;
      hz.flushE = 1'b1;
      hz.flushW = 1'b1;
    end else begin
      hz.forwardAE = fwd_sel(hz.rs1E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW);
      hz.forwardBE = fwd_sel(hz.rs2E, hz.rdM, hz.regWriteM, hz.rdW, hz.regWriteW);
      if (mem_stall) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
        hz.stallM = 1'b1;
        hz.flushW = 1'b1;
      end else begin
        hz.stallF = lw_stall;
        hz.stallD = lw_stall;
        hz.flushE = lw_stall || hz.pcSrcE;
        hz.flushD = hz.pcSrcE;
      end
    end
  end

  assign hz.mem_err   = mem_err_q;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic,
// expected outputs from a rule-level model, compared by a separate monitor.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 64;
  localparam int CNT_W       = 32;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       reg_write_m, reg_write_w, load_e, pc_src_e, mem_req, mem_ready;
  } stim_t;

  typedef struct packed {
    logic [1:0]  fa, fb;
    logic        sf, sd, se, sm, fd, fe, fw;
    logic        regs_known;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  longint m_cnt   = 0;
  bit     m_err   = 0;
  int     m_run   = 0;
  bit     m_known = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic logic [1:0] fwd_model(input logic [4:0] rs, input stim_t s);
    if (rs == 5'd0) return 2'b00;
    if (s.reg_write_m && s.rd_m == rs) return 2'b10;
    if (s.reg_write_w && s.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Expected response: combinational rules for this cycle, registered values
  // reflecting every edge seen so far.
  function automatic exp_t model_now(input stim_t s);
    exp_t e;
    bit   mem, lw;
    e   = '0;
    mem = s.mem_req && !s.mem_ready;
    lw  = s.load_e && s.rd_e != 0 && (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
    if (s.rst) begin
      {e.fd, e.fe, e.fw} = 3'b111;
    end else begin
      e.fa = fwd_model(s.rs1_e, s);
      e.fb = fwd_model(s.rs2_e, s);
      if (mem) begin
        {e.sf, e.sd, e.se, e.sm, e.fw} = 5'b11111;
      end else begin
        e.sf = lw;
        e.sd = lw;
        e.fe = lw | s.pc_src_e;
        e.fd = s.pc_src_e;
      end
    end
    e.regs_known = m_known;
    e.err        = m_err;
    e.cnt        = m_cnt[31:0];
    return e;
  endfunction

  task automatic apply_stimulus(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = s.rst;
    hz.rs1D      = s.rs1_d;
    hz.rs2D      = s.rs2_d;
    hz.rs1E      = s.rs1_e;
    hz.rs2E      = s.rs2_e;
    hz.rdE       = s.rd_e;
    hz.rdM       = s.rd_m;
    hz.rdW       = s.rd_w;
    hz.regWriteM = s.reg_write_m;
    hz.regWriteW = s.reg_write_w;
    hz.loadE     = s.load_e;
    hz.pcSrcE    = s.pc_src_e;
    hz.memReqM   = s.mem_req;
    hz.memReadyM = s.mem_ready;
    e = model_now(s);
    exp_q.push_back(e);
    if (s.rst) begin
      m_cnt   = 0;
      m_err   = 0;
      m_run   = 0;
      m_known = 1;
    end else begin
      if (e.sf && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      m_run = (s.mem_req && !s.mem_ready) ? m_run + 1 : 0;
      if (m_run > MEM_TIMEOUT) m_err = 1;
    end
  endtask

  task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_output(input exp_t e);
    check_field("forwardAE", 32'(hz.forwardAE), 32'(e.fa));
    check_field("forwardBE", 32'(hz.forwardBE), 32'(e.fb));
    check_field("stallF", 32'(hz.stallF), 32'(e.sf));
    check_field("stallD", 32'(hz.stallD), 32'(e.sd));
    check_field("stallE", 32'(hz.stallE), 32'(e.se));
    check_field("stallM", 32'(hz.stallM), 32'(e.sm));
    check_field("flushD", 32'(hz.flushD), 32'(e.fd));
    check_field("flushE", 32'(hz.flushE), 32'(e.fe));
    check_field("flushW", 32'(hz.flushW), 32'(e.fw));
    if (e.regs_known) begin
      check_field("mem_err", 32'(hz.mem_err), 32'(e.err));
      check_field("stall_cnt", hz.stall_cnt, e.cnt);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    int    stall_run;
    rst = 1'b1;
    {hz.rs1D, hz.rs2D, hz.rs1E, hz.rs2E, hz.rdE, hz.rdM, hz.rdW} = '0;
    {hz.regWriteM, hz.regWriteW, hz.loadE, hz.pcSrcE, hz.memReqM, hz.memReadyM} = '0;

    s = idle(); s.rst = 1;
    repeat (2) apply_stimulus(s);

    // Forwarding priority and x0
    s = idle();
    s.rs1_e = 5; s.rd_m = 5; s.reg_write_m = 1; s.rd_w = 5; s.reg_write_w = 1;
    apply_stimulus(s);
    s.rd_m = 0;  apply_stimulus(s);
    s.rs1_e = 0; apply_stimulus(s);

    // Load-use, then the dependent op gets its value forwarded
    s = idle(); s.load_e = 1; s.rd_e = 7; s.rs2_d = 7;
    apply_stimulus(s);
    s = idle(); s.rs2_e = 7; s.rd_w = 7; s.reg_write_w = 1;
    apply_stimulus(s);

    // Taken branch
    s = idle(); s.pc_src_e = 1;
    apply_stimulus(s);

    // Three-cycle memory wait
    s = idle(); s.mem_req = 1;
    repeat (3) apply_stimulus(s);
    s.mem_ready = 1; apply_stimulus(s);
    apply_stimulus(idle());

    // Timeout; branch arriving mid-wait must not flush
    s = idle(); s.mem_req = 1;
    for (int i = 0; i < MEM_TIMEOUT + 2; i++) begin
      s.pc_src_e = (i % 5 == 0);
      apply_stimulus(s);
    end
    s = idle(); s.mem_req = 1; s.mem_ready = 1;
    apply_stimulus(s);
    repeat (3) apply_stimulus(idle());

    // Reset in the middle of a wait, then load-use together with a branch
    s = idle(); s.mem_req = 1;
    repeat (3) apply_stimulus(s);
    s.rst = 1; apply_stimulus(s);
    s.rst = 0; s.mem_ready = 1; apply_stimulus(s);
    s = idle(); s.load_e = 1; s.rd_e = 3; s.rs1_d = 3; s.pc_src_e = 1;
    apply_stimulus(s);
    apply_stimulus(idle());

    // Random traffic over a small register set to make hits common
    stall_run = 0;
    for (int i = 0; i < 500; i++) begin
      s = idle();
      s.rst         = ($urandom_range(0, 63) == 0);
      s.rs1_d       = 5'($urandom_range(0, 3));
      s.rs2_d       = 5'($urandom_range(0, 3));
      s.rs1_e       = 5'($urandom_range(0, 3));
      s.rs2_e       = 5'($urandom_range(0, 3));
      s.rd_e        = 5'($urandom_range(0, 3));
      s.rd_m        = 5'($urandom_range(0, 3));
      s.rd_w        = 5'($urandom_range(0, 3));
      s.reg_write_m = 1'($urandom_range(0, 1));
      s.reg_write_w = 1'($urandom_range(0, 1));
      s.load_e      = 1'($urandom_range(0, 1));
      s.pc_src_e    = ($urandom_range(0, 3) == 0);
      s.mem_req     = ($urandom_range(0, 3) == 0) || (stall_run > 0);
      s.mem_ready   = 1'($urandom_range(0, 1)) || (stall_run >= 8);
      stall_run     = (s.mem_req && !s.mem_ready && !s.rst) ? stall_run + 1 : 0;
      apply_stimulus(s);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
